// File: rtl/jtopl_eg_pkg.sv
// jtopl_eg_pkg: phase encodings, step patterns and rate thresholds for the envelope generator
package jtopl_eg_pkg;
  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } eg_state_e;

  localparam logic [3:0]      HI_RATE  = 4'd12;
  localparam logic [5:0]      MAX_RATE = 6'd60;
  localparam logic [3:0][7:0] PAT      = {8'h7F, 8'h77, 8'h57, 8'h55};

  function automatic logic [5:0] eff_rate(input logic [3:0] base, input logic [3:0] ks);
    logic [6:0] r;
    r = {1'b0, base, 2'b00} + {3'b000, ks};
    return base == 4'd0 ? 6'd0 : (r > 7'd63 ? 6'd63 : r[5:0]);
  endfunction
endpackage

// File: rtl/jtopl_eg_chan_if.sv
// jtopl_eg_chan_if: register-file inputs and operator-side outputs of the envelope channel
interface jtopl_eg_chan_if #(
  parameter int N_SLOTS = 18,
  parameter int EGW     = 10
);
  localparam int SW = $clog2(N_SLOTS);
  logic           cen;
  logic [SW-1:0]  slot_in;
  logic           keyon;
  logic [3:0]     ar;
  logic [3:0]     dr;
  logic [3:0]     rr;
  logic [3:0]     sl;
  logic [3:0]     ks_ofs;
  logic           sus_en;
  logic [EGW-1:0] eg_out;
  logic [1:0]     state_out;
  logic [SW-1:0]  slot_out;
  logic           sweep;

  modport master (
    output cen, keyon, ar, dr, rr, sl, ks_ofs, sus_en,
    input  slot_in, eg_out, state_out, slot_out, sweep
  );
  modport slave (
    input  cen, keyon, ar, dr, rr, sl, ks_ofs, sus_en,
    output slot_in, eg_out, state_out, slot_out, sweep
  );
endinterface

// File: rtl/jtopl_eg_step.sv
// jtopl_eg_step: one envelope update of a slot from its effective rate and the global counter
module jtopl_eg_step
  import jtopl_eg_pkg::*;
#(
  parameter int EGW  = 10,
  parameter int CNTW = 15
) (
  input  logic [5:0]      rate_i,
  input  logic [CNTW-1:0] cnt_i,
  input  logic            atk_i,
  input  logic [EGW-1:0]  eg_i,
  output logic [EGW-1:0]  eg_o
);
  logic [3:0]     h;
  logic [1:0]     l;
  logic [3:0]     s;
  logic [2:0]     idx;
  logic           step;
  logic [3:0]     inc;
  logic [EGW-1:0] ash;
  logic [EGW:0]   a;
  logic [EGW:0]   sub;
  logic [EGW:0]   sum;
  logic [EGW:0]   dif;

  always_comb begin
    h    = rate_i[5:2];
    l    = rate_i[1:0];
    s    = h < HI_RATE ? 4'd11 - h : 4'd0;
    idx  = 3'({3'b000, cnt_i} >> s);
    step = ((cnt_i & ((CNTW'(1) << s) - CNTW'(1))) == '0) && PAT[l][idx];
    inc  = h < HI_RATE ? (step ? 4'd2 : 4'd0) :
           h == 4'd12  ? (step ? 4'd2 : 4'd1) :
           h == 4'd13  ? (step ? 4'd4 : 4'd2) :
           h == 4'd14  ? (step ? 4'd8 : 4'd4) : 4'd8;
    ash  = h <= HI_RATE ? eg_i >> 4 : h == 4'd13 ? eg_i >> 3 : eg_i >> 2;
    a    = {1'b0, ash} + (EGW+1)'(1);
    sub  = h >= HI_RATE ? (step ? a << 1 : a) : (step ? a : '0);
    // one spare bit flags carry out of the add and borrow out of the subtract
    sum  = {1'b0, eg_i} + (EGW+1)'(inc);
    dif  = {1'b0, eg_i} - sub;
    eg_o = rate_i == 6'd0 ? eg_i :
           !atk_i ? (sum[EGW] ? '1 : sum[EGW-1:0]) :
           (rate_i >= MAX_RATE || dif[EGW]) ? '0 : dif[EGW-1:0];
  end
endmodule

// File: rtl/jtopl_eg_chan.sv
// jtopl_eg_chan: time-multiplexed ADSR envelope generator, one slot per clock enable
module jtopl_eg_chan
  import jtopl_eg_pkg::*;
#(
  parameter int N_SLOTS = 18,
  parameter int EGW     = 10,
  parameter int CNTW    = 15
) (
  input logic            clk,
  input logic            rst_n,
  jtopl_eg_chan_if.slave bus
);
  localparam int SW = $clog2(N_SLOTS);

  logic [SW-1:0]      slot_q;
  logic [SW-1:0]      slot_d;
  logic [CNTW-1:0]    cnt_q;
  logic [EGW-1:0]     eg_q [N_SLOTS];
  eg_state_e          st_q [N_SLOTS];
  logic [N_SLOTS-1:0] kp_q;
  logic [EGW-1:0]     eg_out_q;
  eg_state_e          st_out_q;
  logic [SW-1:0]      slot_out_q;
  logic               sweep_q;
  logic [EGW-1:0]     eg_cur;
  logic [EGW-1:0]     eg_d;
  logic [EGW-1:0]     thr;
  eg_state_e          st_cur;
  eg_state_e          st_d;
  eg_state_e          ph;
  logic               last;
  logic               kon_e;
  logic               koff_e;
  logic [3:0]         base;
  logic [5:0]         rate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      cnt_q      <= '0;
      kp_q       <= '0;
      eg_out_q   <= '1;
      st_out_q   <= RELEASE;
      slot_out_q <= '0;
      sweep_q    <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        eg_q[i] <= '1;
        st_q[i] <= RELEASE;
      end
    end else if (bus.cen) begin
      slot_q       <= slot_d;
      cnt_q        <= cnt_q + CNTW'(last);
      eg_q[slot_q] <= eg_d;
      st_q[slot_q] <= st_d;
      kp_q[slot_q] <= bus.keyon;
      eg_out_q     <= eg_d;
      st_out_q     <= st_d;
      slot_out_q   <= slot_q;
      sweep_q      <= slot_q == '0;
    end
  end

  always_comb begin
    slot_d = last ? '0 : slot_q + SW'(1);
    st_d   = kon_e  ? ATTACK :
             koff_e ? RELEASE :
             (st_cur == ATTACK && eg_d == '0) ? DECAY :
             (st_cur == DECAY && eg_d >= thr) ? SUSTAIN : st_cur;
  end

  // a key edge switches phase before the update, so the new phase's rate applies this visit
  always_comb begin
    last   = slot_q == SW'(N_SLOTS - 1);
    eg_cur = eg_q[slot_q];
    st_cur = st_q[slot_q];
    kon_e  = bus.keyon & ~kp_q[slot_q];
    koff_e = ~bus.keyon & kp_q[slot_q];
    ph     = kon_e ? ATTACK : koff_e ? RELEASE : st_cur;
    base   = ph == ATTACK ? bus.ar : ph == DECAY ? bus.dr :
             ph == SUSTAIN ? (bus.sus_en ? 4'd0 : bus.rr) : bus.rr;
    rate   = eff_rate(base, bus.ks_ofs);
    thr    = bus.sl == 4'hF ? '1 : {bus.sl, {(EGW-4){1'b0}}};
  end

  jtopl_eg_step #(.EGW(EGW), .CNTW(CNTW)) u_step (
    .rate_i (rate),
    .cnt_i  (cnt_q),
    .atk_i  (ph == ATTACK),
    .eg_i   (eg_cur),
    .eg_o   (eg_d)
  );

  assign bus.slot_in   = slot_q;
  assign bus.eg_out    = eg_out_q;
  assign bus.state_out = st_out_q;
  assign bus.slot_out  = slot_out_q;
  assign bus.sweep     = sweep_q;
endmodule

// File: doc/jtopl_eg_chan.md
# jtopl_eg_chan

Time-multiplexed, parametrised envelope generator for the JTOPL operator pipeline. It holds the envelope attenuation and ADSR phase for `N_SLOTS` operator slots, visits one slot per clock-enable and advances that slot's attenuation using a global envelope counter. It sits between the register file, which supplies per-slot rates, and the operator/phase stage, which consumes `eg_out`. Compared with the single-step combinational envelope arithmetic, this block adds configurable attenuation width and slot count, per-slot state storage, key-edge detection, sustain-level compare and rate-pattern step generation.

## Interface
- `N_SLOTS`, 18: number of time-multiplexed slots; must be ≥2.
- `EGW`, 10: attenuation width in bits; must be ≥8. All-ones means silence.
- `CNTW`, 15: width of the global envelope counter.
- `clk` input 1: clock, used for all state.
- `rst_n` input 1: asynchronous reset, active low.
- `cen` input 1: clock enable. State changes only on cycles with `cen` high.
- `slot_in` output $clog2(N_SLOTS): slot whose inputs are being sampled this `cen`.
- `keyon` input 1: key state of slot `slot_in`.
- `ar`, `dr`, `rr` input 4 each: attack, decay and release rates.
- `sl` input 4: sustain level.
- `ks_ofs` input 4: key-scale rate offset, added to the effective rate.
- `sus_en` input 1: 1 = hold at sustain; 0 = percussive, which continues with `rr` after sustain.
- `eg_out` output EGW: updated attenuation of `slot_out`.
- `state_out` output 2: phase of `slot_out`. ATTACK=0, DECAY=1, SUSTAIN=2, RELEASE=3.
- `slot_out` output $clog2(N_SLOTS): slot index for `eg_out` and `state_out`.
- `sweep` output 1: one-`cen` pulse when `slot_in` wraps from N_SLOTS-1 to 0.

## Operation
- Slot counter `slot_in` increments on each `cen` and wraps at N_SLOTS-1. `eg_cnt` (CNTW bits, free-running, wraps) increments on each wrap.
- Per-slot storage: `eg` (EGW bits), `state` (2 bits), `kprev` (1 bit).
- Phase selects the base rate: ATTACK uses `ar`, DECAY uses `dr`, SUSTAIN uses 0 if `sus_en` else `rr`, RELEASE uses `rr`.
- Effective rate: R = base==0 ? 0 : min(63, 4·base + ks_ofs). R==0 means no change.
- Step: let h=R[5:2], l=R[1:0].
  - If h<12: s = 11-h. `step` = (eg_cnt[s-1:0]==0, true when s=0) and PAT[l][eg_cnt[s+2:s]].
  - If h≥12: `step` = PAT[l][eg_cnt[2:0]].
  - PAT (bit 7..0): l0=01010101, l1=01010111, l2=01110111, l3=01111111.
- Decay and release increment, added with saturation at all-ones:
  - h<12: step?2:0.
  - h=12: step?2:1.
  - h=13: step?4:2.
  - h=14: step?8:4.
  - h=15: 8.
- Attack decrement: a = (eg>>4)+1 for h≤12, (eg>>3)+1 for h=13, (eg>>2)+1 for h≥14.
  - Subtract h≥12 ? (step?2a:a) : (step?a:0).
  - Clamp at 0 on underflow.
  - R≥60 forces eg=0.
- Transitions, evaluated in this priority order:
  1. keyon & !kprev: go to ATTACK.
  2. !keyon & kprev: go to RELEASE.
  3. ATTACK with new eg==0: go to DECAY.
  4. DECAY with new eg ≥ {sl, (EGW-4)'b0}: go to SUSTAIN. If sl==15, compare against all-ones.
- A key-on edge keeps the current eg; attack starts from it.
- `kprev` is updated to `keyon` on every visit.
- Arithmetic is done at EGW+1 bits to detect overflow and underflow.

## Timing
- Inputs for slot s are sampled on the `cen` edge where `slot_in`==s.
- Outputs for slot s are registered on that same edge. `slot_out`=s is valid from the next cycle until the next `cen`, so latency is 1 `cen`.
- `sweep` is registered and asserted for the `cen` period in which `slot_out`=0.
- Reset values:
  - slot counter and `slot_in`: 0.
  - `eg_cnt`: 0.
  - every slot: eg=all-ones, state=RELEASE, kprev=0.
  - `eg_out`: all-ones.
  - `state_out`: 3.
  - `slot_out`: 0.
  - `sweep`: 0.
- Reset mid-sweep restarts at slot 0 with the reset values above. No partial update is kept.
- With `cen` low, all registers hold.

## Structure
- Package `jtopl_eg_pkg`: phase encodings, PAT table, rate-threshold constants (12, 60).
- Sub-module `jtopl_eg_step`: combinational. Takes R, `eg_cnt`, phase and eg; returns the new eg. It is parametrised by EGW and CNTW.
- Top level holds the slot counter, `eg_cnt`, per-slot storage arrays and the phase FSM.

## Test plan
- Reset, then run N_SLOTS `cen` cycles. Expect all slots eg=0x3FF, state 3, and one `sweep` pulse per wrap.
- Slot 0 with keyon=1 and ar=15 (R≥60). Expect eg=0 on the first visit and DECAY on the next visit.
- Slot 2 with ar=10 and ks_ofs=0. Expect eg to decrease monotonically, reach 0, and then state=1.
- DECAY with dr=12, sl=4 and sus_en=1. Expect SUSTAIN when eg ≥ 0x100, then eg constant.
- sus_en=0 in SUSTAIN with rr=8. Expect eg to keep rising to 0x3FF and hold there without wrapping.
- keyon toggled 1→0→1 mid-attack on one slot:
  - RELEASE is entered on the visit with the falling edge.
  - ATTACK is re-entered on the visit with the rising edge, starting from the current eg.
  - Other slots are unaffected.
